// File: rtl/mod_csum_pkg.sv
// Shared constants for the streaming ones'-complement checksum checker.
package mod_csum_pkg;

    typedef logic [1:0] csum_state_t;

    localparam csum_state_t ST_IDLE  = 2'd0;
    localparam csum_state_t ST_ACCUM = 2'd1;
    localparam csum_state_t ST_DONE  = 2'd2;

    localparam int DEFAULT_MAX_WORDS = 1500;

    // All-ones mask for word widths up to 64 bits; callers truncate to their width.
    function automatic logic [63:0] all_ones_mask(input int width);
        return {64{1'b1}} >> (64 - width);
    endfunction

endpackage

// File: rtl/mod_csum_fold.sv
// Combinational WIDTH-bit ones'-complement adder with end-around carry.
module mod_csum_fold #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum_wide;

    // Re-adding the carry cannot overflow again: the worst case all-ones + all-ones
    // leaves a low part of all-ones minus one.
    assign sum_wide = {1'b0, acc} + {1'b0, data};
    assign acc_next = sum_wide[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, sum_wide[WIDTH]};

endmodule

// File: rtl/mod_csum_checker.sv
// Streaming ones'-complement checksum checker with a held result interface.
// Optional packet-length check compiled in with `define MOD_CSUM_MAXLEN_EN.
module mod_csum_checker
    import mod_csum_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_W     = 16,
    parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_ok,
    output logic [CNT_W-1:0] res_count,
    output logic             res_len_err
);

    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones_mask(WIDTH));

    if (WIDTH < 8 || WIDTH > 64 || MAX_WORDS < 1) begin : g_bad_config
        $error("mod_csum_checker: unsupported WIDTH or MAX_WORDS");
    end

    csum_state_t      state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] res_sum_reg;
    logic             res_ok_reg;
    logic [CNT_W-1:0] res_count_reg;
    logic             len_err_next;
    logic             ok_next;
    logic             beat;

    mod_csum_fold #(.WIDTH(WIDTH)) u_fold (
        .acc      (acc_reg),
        .data     (in_data),
        .acc_next (acc_next)
    );

    assign res_valid = (state_reg == ST_DONE);
    assign in_ready  = !res_valid;
    assign beat      = in_valid && in_ready;
    assign cnt_next  = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
    assign ok_next   = (acc_next == ALL_ONES) && !len_err_next;

`ifdef MOD_CSUM_MAXLEN_EN
    logic len_err_reg;
    logic res_len_err_reg;

    // Sticky: once the packet has run past MAX_WORDS it stays flagged until its result is taken.
    assign len_err_next = len_err_reg || (cnt_next > CNT_W'(MAX_WORDS));
    assign res_len_err  = res_len_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            len_err_reg     <= 1'b0;
            res_len_err_reg <= 1'b0;
        end else if (beat) begin
            len_err_reg <= len_err_next;
            if (in_last) begin
                res_len_err_reg <= len_err_next;
            end
        end else if (res_valid && res_ready) begin
            len_err_reg <= 1'b0;
        end
    end
`else
    assign len_err_next = 1'b0;
    assign res_len_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            res_sum_reg   <= '0;
            res_ok_reg    <= 1'b0;
            res_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_ACCUM: begin
                    if (beat) begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_next;
                        if (in_last) begin
                            state_reg     <= ST_DONE;
                            res_sum_reg   <= acc_next;
                            res_ok_reg    <= ok_next;
                            res_count_reg <= cnt_next;
                        end else begin
                            state_reg <= ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    // Result registers stay untouched here so they hold under back-pressure.
                    if (res_ready) begin
                        state_reg <= ST_IDLE;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign res_sum   = res_sum_reg;
    assign res_ok    = res_ok_reg;
    assign res_count = res_count_reg;

endmodule

// File: tb/tb_mod_csum_checker.sv
// Directed self-checking bench for mod_csum_checker (16-bit words, MAX_WORDS=4).
module tb_mod_csum_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_sum;
    logic        res_ok;
    logic [15:0] res_count;
    logic        res_len_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mod_csum_checker #(.WIDTH(16), .CNT_W(16), .MAX_WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_ok      (res_ok),
        .res_count   (res_count),
        .res_len_err (res_len_err)
    );

    // Presents one beat and returns #1 after the edge that transferred it.
    task automatic send_beat(input logic [15:0] d, input logic l);
        int waits = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (in_ready !== 1'b1 && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic accept_result(input string name);
        $display("result %s: sum=%h ok=%b count=%0d len_err=%b", name, res_sum, res_ok, res_count, res_len_err);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [15:0] sum, input logic ok,
                                input logic [15:0] cnt, input logic lerr);
        n_checks++;
        if (res_valid !== 1'b1) begin n_fail++; $display("FAIL %s valid: got %b want 1", name, res_valid); end
        n_checks++;
        if (res_sum !== sum) begin n_fail++; $display("FAIL %s sum: got %h want %h", name, res_sum, sum); end
        n_checks++;
        if (res_ok !== ok) begin n_fail++; $display("FAIL %s ok: got %b want %b", name, res_ok, ok); end
        n_checks++;
        if (res_count !== cnt) begin n_fail++; $display("FAIL %s count: got %0d want %0d", name, res_count, cnt); end
        n_checks++;
        if (res_len_err !== lerr) begin n_fail++; $display("FAIL %s len_err: got %b want %b", name, res_len_err, lerr); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s in_ready: got %b want 0", name, in_ready); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b want 0", res_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        n_checks++;
        if (res_sum !== 16'h0000) begin n_fail++; $display("FAIL reset sum: got %h want 0000", res_sum); end
        n_checks++;
        if ({res_ok, res_len_err} !== 2'b00) begin n_fail++; $display("FAIL reset ok/len_err: got %b want 00", {res_ok, res_len_err}); end
        n_checks++;
        if (res_count !== 16'd0) begin n_fail++; $display("FAIL reset count: got %0d want 0", res_count); end
        $display("reset: valid=%b in_ready=%b", res_valid, in_ready);
    endtask

    task automatic test_basic;
        // Idle junk with in_valid low must not start a packet.
        in_data = 16'hFFFF;
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_last = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ignore valid: got %b want 0", res_valid); end
        send_beat(16'h4500, 1'b0);
        send_beat(16'h0030, 1'b0);
        send_beat(16'hBACF, 1'b1);
        check_result("basic", 16'hFFFF, 1'b1, 16'd3, 1'b0);
        accept_result("basic");
        n_checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic release: got valid=%b in_ready=%b want 0/1", res_valid, in_ready);
        end
    endtask

    task automatic test_carry;
        send_beat(16'h8000, 1'b0);
        send_beat(16'h8000, 1'b0);
        send_beat(16'hFFFE, 1'b1);
        check_result("carry", 16'hFFFF, 1'b1, 16'd3, 1'b0);
        accept_result("carry");
        // Double all-ones folds back to all-ones.
        send_beat(16'hFFFF, 1'b0);
        send_beat(16'hFFFF, 1'b1);
        check_result("double_ones", 16'hFFFF, 1'b1, 16'd2, 1'b0);
        accept_result("double_ones");
    endtask

    task automatic test_corrupt;
        send_beat(16'h4500, 1'b0);
        send_beat(16'h0030, 1'b0);
        send_beat(16'hBACE, 1'b1);
        check_result("corrupt", 16'hFFFE, 1'b0, 16'd3, 1'b0);
        accept_result("corrupt");
    endtask

    task automatic test_zero_payload;
        send_beat(16'h0000, 1'b0);
        send_beat(16'h0000, 1'b0);
        send_beat(16'hFFFF, 1'b1);
        check_result("zero_payload", 16'hFFFF, 1'b1, 16'd3, 1'b0);
        accept_result("zero_payload");
    endtask

    task automatic test_back_to_back;
        send_beat(16'h4500, 1'b0);
        send_beat(16'h0030, 1'b0);
        send_beat(16'hBACF, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (in_ready !== 1'b0 || res_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_ready cycle %0d: got in_ready=%b valid=%b want 0/1", i, in_ready, res_valid);
            end
            n_checks++;
            if (res_sum !== 16'hFFFF || res_count !== 16'd3 || res_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_stable cycle %0d: got sum=%h count=%0d ok=%b want FFFF/3/1", i, res_sum, res_count, res_ok);
            end
        end
        accept_result("held");
        n_checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bubble: got valid=%b in_ready=%b want 0/1", res_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("after_bubble", 16'h1234, 1'b0, 16'd1, 1'b0);
        accept_result("after_bubble");
    endtask

    task automatic test_reset_mid;
        send_beat(16'h1111, 1'b0);
        send_beat(16'h2222, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid state: got valid=%b in_ready=%b want 0/1", res_valid, in_ready);
        end
        send_beat(16'hFFFF, 1'b1);
        check_result("reset_mid", 16'hFFFF, 1'b1, 16'd1, 1'b0);
        accept_result("reset_mid");
    endtask

    task automatic test_max_len;
        send_beat(16'h4500, 1'b0);
        send_beat(16'h0030, 1'b0);
        send_beat(16'h0000, 1'b0);
        send_beat(16'h0000, 1'b0);
        send_beat(16'hBACF, 1'b1);
`ifdef MOD_CSUM_MAXLEN_EN
        check_result("max_len", 16'hFFFF, 1'b0, 16'd5, 1'b1);
`else
        check_result("max_len", 16'hFFFF, 1'b1, 16'd5, 1'b0);
`endif
        accept_result("max_len");
        // Four words is still legal and the flag must not carry over.
        send_beat(16'h4500, 1'b0);
        send_beat(16'h0030, 1'b0);
        send_beat(16'h0000, 1'b0);
        send_beat(16'hBACF, 1'b1);
        check_result("len_four", 16'hFFFF, 1'b1, 16'd4, 1'b0);
        accept_result("len_four");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_corrupt();
        test_zero_payload();
        test_back_to_back();
        test_reset_mid();
        test_max_len();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_csum_checker.md
Name: mod_csum_checker

Overview:
- Streaming ones'-complement (mod 2^WIDTH-1) checksum checker. Receive-side counterpart to the end-around-carry modular adders used on the generate side.
- Accepts a packet of WIDTH-bit words, checksum word included, over a valid/ready stream.
- Folds every beat into an accumulator with end-around carry.
- On the last beat, presents the final sum, word count and a pass/fail verdict on a held result interface.

Parameters:
- WIDTH, 16, data word width in bits (>=8).
- CNT_W, 16, width of the word counter and res_count.
- MAX_WORDS, 1500, longest legal packet in words. Used only when the optional feature is compiled in.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  checker can accept a beat.
- in_data  input  WIDTH  data or checksum word.
- in_last  input  1  final beat of the packet.
- res_valid  output  1  result available; held until accepted.
- res_ready  input  1  result consumer accepts.
- res_sum  output  WIDTH  final folded ones'-complement sum.
- res_ok  output  1  1 = checksum correct.
- res_count  output  CNT_W  words in packet, saturating at 2^CNT_W-1.
- res_len_err  output  1  packet longer than MAX_WORDS (optional feature only).

Behaviour:
- Reset (synchronous, rst=1 at a clock edge): state=IDLE, acc=0, cnt=0, res_valid=0, res_sum=0, res_ok=0, res_count=0, res_len_err=0. Reset mid-packet discards the partial packet, including a pending unaccepted result.
- Beat transfer occurs when in_valid && in_ready. Result transfer occurs when res_valid && res_ready.
- in_ready = !res_valid, combinational from state. It is 1 in IDLE and ACCUM and 0 in DONE.
- Accumulate step: s = acc + in_data (WIDTH+1 bits); acc_next = s[WIDTH-1:0] + s[WIDTH]. This never overflows a second time: 0xFFFF + 0xFFFF folds to 0xFFFF.
- cnt_next = cnt + 1, saturating at 2^CNT_W-1.
- FSM:
  - IDLE: on a beat without in_last -> ACCUM, with acc = fold(0 + data) and cnt = 1. On a beat with in_last (single-word packet) -> DONE.
  - ACCUM: each beat updates acc and cnt. A beat with in_last -> DONE.
  - DONE: res_valid=1. res_sum, res_ok, res_count and res_len_err are registered and stable. On a result transfer -> IDLE, with acc=0, cnt=0 and res_valid=0 on the next cycle.
- Latency: a last beat accepted at edge t makes res_valid=1 after edge t. There is a one-cycle bubble after each result transfer before in_ready rises.
- Verdict: res_ok = (res_sum == all-ones). Both zero encodings are handled by this rule: all-zero payload plus checksum 0xFFFF gives 0xFFFF, which passes.
- in_valid while in DONE is back-pressured; no beat is lost.
- in_data and in_last are ignored when in_valid=0.
- res_* outputs must not change while res_valid=1 and res_ready=0.

Optional Feature:
- Macro MOD_CSUM_MAXLEN_EN.
- Defined: if cnt would exceed MAX_WORDS, a sticky length-error flag is set. At DONE, res_len_err=1 and res_ok is forced to 0. Accumulation continues until in_last, and res_sum is still reported.
- Undefined: no comparator and no flag. res_len_err is tied to 0, and res_ok depends only on the sum.

Decomposition:
- Package mod_csum_pkg holds:
  - state enum (IDLE, ACCUM, DONE);
  - function or constant for all-ones of WIDTH;
  - default MAX_WORDS constant.
- One sub-module: mod_csum_fold, the combinational WIDTH-bit end-around-carry adder (acc, data -> acc_next), instantiated once for the accumulate step.

Test Plan:
- Beats 0x4500, 0x0030, 0xBACF (last) -> res_sum=0xFFFF, res_ok=1, res_count=3, res_valid one cycle after the last beat.
- Beats 0x8000, 0x8000, 0xFFFE (last): end-around carry, 0x10000 folds to 0x0001 -> res_sum=0xFFFF, res_ok=1.
- Beats 0x4500, 0x0030, 0xBACE (corrupted checksum) -> res_sum=0xFFFE, res_ok=0.
- Hold res_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout, res_* stable. Raise res_ready -> IDLE, next packet accepted after the one-cycle bubble.
- Assert rst mid-packet after 2 beats, then send single beat 0xFFFF (last) -> res_count=1, res_sum=0xFFFF, res_ok=1.
- With MOD_CSUM_MAXLEN_EN and MAX_WORDS=4: a 5-beat valid-checksum packet -> res_len_err=1, res_ok=0, res_count=5. Without the macro -> res_len_err=0, res_ok=1.
